mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised MEM pipeline stage: EX->MEM pipeline register, load/store unit driving a variable-latency SRAM-like data bus (req/addr_ok/data_ok), byte/half/word access with sign/zero extension, misalignment detection, stall request, forwarding bus.
- Sits between EX and WB. Result goes to the regfile forwarding path (ID) and to WB.

Parameters:
- PC_W, 32, PC field width.
- RF_ADDR_W, 5, register-file address width.
- STALL_W, 6, width of the stall vector.
- EX_W, PC_W+RF_ADDR_W+70, ex_to_mem_bus width.
- WB_W, PC_W+RF_ADDR_W+33, mem_to_wb_bus width.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset: asynchronous, active-low.
- stall, in, STALL_W, pipeline stall vector; stall[3] holds this stage's input register, stall[4] holds the next stage.
- ex_to_mem_bus, in, EX_W, fields MSB->LSB: pc[PC_W], mem_en, mem_we, mem_type[2:0], rf_we, rf_waddr[RF_ADDR_W], ex_result[32] (ALU result or byte address), store_data[32].
- data_req, out, 1, memory request valid.
- data_wr, out, 1, 1 = store.
- data_size, out, 2, 0 = byte, 1 = half, 2 = word.
- data_addr, out, 32, byte address (= ex_result).
- data_wstrb, out, 4, byte write strobes.
- data_wdata, out, 32, aligned store data.
- data_addr_ok, in, 1, request accepted.
- data_data_ok, in, 1, response valid (read data or write done).
- data_rdata, in, 32, read data.
- stallreq_mem, out, 1, stage busy; freeze pipeline.
- excp_ale, out, 1, address-alignment or reserved-type error for the current instruction.
- mem_to_rf_bus, out, RF_ADDR_W+33, {rf_we, rf_waddr, rf_wdata} forwarding to ID.
- mem_to_wb_bus, out, WB_W, {pc, rf_we, rf_waddr, rf_wdata}.

Behaviour:
- Input register, EX_W bits:
  - Reset to 0.
  - If stall[3]=1 and stall[4]=0: load 0 (bubble).
  - Else if stall[3]=0: load ex_to_mem_bus.
  - Else: hold.
- mem_type encoding: 000 B (signed), 001 BU, 010 H (signed), 011 HU, 100 W; 101-111 reserved.
- excp_ale is combinational. It is 1 when mem_en=1 and any of:
  - type is reserved;
  - type is H/HU and addr[0]=1;
  - type is W and addr[1:0]!=0.
- With excp_ale=1: no request is issued, stallreq_mem=0, and rf_we is forced to 0 on both output buses.
- FSM states IDLE, REQ, WAIT, DONE; reset state is IDLE.
  - IDLE: if mem_en & !excp_ale, data_req=1 combinationally. addr_ok -> WAIT; addr_ok & data_ok in the same cycle -> DONE; otherwise -> REQ.
  - REQ: data_req=1, holding all outputs stable. addr_ok -> WAIT, or -> DONE if data_ok is also high.
  - WAIT: data_req=0. data_ok -> capture data_rdata into rbuf, -> DONE.
  - DONE: data_req=0. Hold until the input register loads (stall[3]=0 or bubble), then -> IDLE.
- data_ok seen in IDLE or DONE is ignored.
- stallreq_mem = mem_en & !excp_ale & (state!=DONE). It is combinational, so it is high in the issue cycle.
- The controller guarantees stall[4:3]=11 while stallreq_mem=1.
- Store lane formatting:
  - B: wstrb = 0001<<addr[1:0]; wdata = byte replicated x4.
  - H: wstrb = 0011<<addr[1:0]; wdata = half replicated x2.
  - W: wstrb = 1111.
  - Loads drive wstrb = 0.
- Load extraction from rbuf: select byte/half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
- rf_wdata = extracted load data if (mem_en & !mem_we), else ex_result.
- While a load has not reached DONE, rf_we=0 on both buses, so no stale data is forwarded.
- Stores: rf_we passes through as decoded; EX guarantees it is 0 for stores.
- Latency:
  - Non-memory instruction: 0 extra cycles.
  - Memory op: 1 + addr_ok wait + data_ok wait cycles of stall.
  - Minimum: 1 stall cycle (addr_ok and data_ok both in the issue cycle).
- Reset mid-operation: FSM -> IDLE and register -> 0 asynchronously; data_req drops immediately. The slave shares rst, so no orphan response is tracked.
- All outputs reset to 0.

Test Plan:
- LB addr 0x00001003; addr_ok in the issue cycle, data_ok 2 cycles later, rdata 0x80FF1234 -> data_size=0, stallreq_mem high 3 cycles, then rf_wdata=0xFFFFFF80 with rf_we=1 on both buses.
- SH addr 0x00002002, store_data 0x0000ABCD, addr_ok and data_ok delayed 1 cycle each -> data_wr=1, wstrb=1100, wdata=0xABCDABCD, data_req held stable through REQ.
- LW addr 0x00001001 -> excp_ale=1, data_req never asserts, stallreq_mem=0, rf_we=0; reserved mem_type=101 at an aligned address gives the same result.
- LHU addr 0x00000002, addr_ok and data_ok in the same issue cycle, rdata 0x80010000 -> 1-cycle stall, rf_wdata=0x00008001.
- stall[3]=1, stall[4]=0 on a valid ADD -> next cycle register is 0, wb bus pc=0, rf_we=0; with stall[3]=stall[4]=1 the register holds its value.
- rst driven low during WAIT -> data_req, stallreq_mem and both buses are 0 in the same cycle. After release, a new LW issues from IDLE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM stage: EX->MEM register, load/store unit on a req/addr_ok/data_ok
// data bus, lane formatting, load extension and forwarding buses.
module mem_stage_lsu #(
   parameter int PC_W      = 32,
   parameter int RF_ADDR_W = 5,
   parameter int STALL_W   = 6,
   parameter int EX_W      = PC_W + RF_ADDR_W + 70,
   parameter int WB_W      = PC_W + RF_ADDR_W + 33
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_W-1:0]     stall,
   input  logic [EX_W-1:0]        ex_to_mem_bus,
   output logic                   data_req,
   output logic                   data_wr,
   output logic [1:0]             data_size,
   output logic [31:0]            data_addr,
   output logic [3:0]             data_wstrb,
   output logic [31:0]            data_wdata,
   input  logic                   data_addr_ok,
   input  logic                   data_data_ok,
   input  logic [31:0]            data_rdata,
   output logic                   stallreq_mem,
   output logic                   excp_ale,
   output logic [RF_ADDR_W+32:0]  mem_to_rf_bus,
   output logic [WB_W-1:0]        mem_to_wb_bus
);

   localparam int WA_L = 64;
   localparam int WE_B = WA_L + RF_ADDR_W;
   localparam int MT_L = WE_B + 1;
   localparam int MW_B = MT_L + 3;
   localparam int ME_B = MW_B + 1;
   localparam int PC_L = ME_B + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state, state_n;
   logic [EX_W-1:0]      ex_r;
   logic [31:0]          rbuf;
   logic                 cap;
   logic                 load_en;

   logic [PC_W-1:0]      pc;
   logic                 mem_en, mem_we, rf_we;
   logic [2:0]           mem_type;
   logic [RF_ADDR_W-1:0] rf_waddr;
   logic [31:0]          ex_result, store_data;
   logic [1:0]           off;

   logic                 is_b, is_h, is_w, rsvd;
   logic                 mem_op, is_load;
   logic [3:0]           strb_raw;
   logic [7:0]           lb;
   logic [15:0]          lh;
   logic [31:0]          ld_data, rf_wdata;
   logic                 rf_we_o;
   logic                 unused_stall;

   assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

   // stall[3]=1,stall[4]=0 injects a bubble; both set holds
   assign load_en = ~stall[3] | ~stall[4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_r <= '0;
      end else if (stall[3] && !stall[4]) begin
         ex_r <= '0;
      end else if (!stall[3]) begin
         ex_r <= ex_to_mem_bus;
      end
   end

   assign store_data = ex_r[31:0];
   assign ex_result  = ex_r[63:32];
   assign rf_waddr   = ex_r[WA_L +: RF_ADDR_W];
   assign rf_we      = ex_r[WE_B];
   assign mem_type   = ex_r[MT_L +: 3];
   assign mem_we     = ex_r[MW_B];
   assign mem_en     = ex_r[ME_B];
   assign pc         = ex_r[PC_L +: PC_W];
   assign off        = ex_result[1:0];

   assign is_b = (mem_type[2:1] == 2'b00);
   assign is_h = (mem_type[2:1] == 2'b01);
   assign is_w = (mem_type == 3'b100);
   assign rsvd = mem_type[2] & (|mem_type[1:0]);

   assign excp_ale = mem_en & (rsvd
                   | (is_h & off[0])
                   | (is_w & (|off)));
   assign mem_op   = mem_en & ~excp_ale;
   assign is_load  = mem_en & ~mem_we;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rbuf <= '0;
      end else if (cap) begin
         rbuf <= data_rdata;
      end
   end

   always_comb begin
      state_n  = state;
      data_req = 1'b0;
      cap      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (mem_op) begin
               data_req = 1'b1;
               if (data_addr_ok && data_data_ok) begin
                  cap     = 1'b1;
                  state_n = S_DONE;
               end else if (data_addr_ok) begin
                  state_n = S_WAIT;
               end else begin
                  state_n = S_REQ;
               end
            end
         end
         S_REQ: begin
            data_req = mem_op;
            if (data_addr_ok) begin
               if (data_data_ok) begin
                  cap     = 1'b1;
                  state_n = S_DONE;
               end else begin
                  state_n = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (data_data_ok) begin
               cap     = 1'b1;
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            if (load_en) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign stallreq_mem = mem_op & (state != S_DONE);

   always_comb begin
      data_size  = 2'd0;
      strb_raw   = 4'b0000;
      data_wdata = store_data;
      unique case (1'b1)
         is_b: begin
            data_size  = 2'd0;
            strb_raw   = 4'b0001 << off;
            data_wdata = {4{store_data[7:0]}};
         end
         is_h: begin
            data_size  = 2'd1;
            strb_raw   = 4'b0011 << off;
            data_wdata = {2{store_data[15:0]}};
         end
         is_w: begin
            data_size  = 2'd2;
            strb_raw   = 4'b1111;
         end
         default: begin
            data_size  = 2'd0;
         end
      endcase
   end

   assign data_wr    = mem_en & mem_we;
   assign data_addr  = ex_result;
   assign data_wstrb = (mem_en & mem_we) ? strb_raw : 4'b0000;

   assign lb = rbuf[{off, 3'b000} +: 8];
   assign lh = off[1] ? rbuf[31:16] : rbuf[15:0];

   always_comb begin
      ld_data = rbuf;
      case (mem_type)
         3'b000:  ld_data = {{24{lb[7]}}, lb};
         3'b001:  ld_data = {24'h0, lb};
         3'b010:  ld_data = {{16{lh[15]}}, lh};
         3'b011:  ld_data = {16'h0, lh};
         default: ld_data = rbuf;
      endcase
   end

   assign rf_wdata = is_load ? ld_data : ex_result;
   // a load only forwards once its data is in rbuf
   assign rf_we_o  = rf_we & ~excp_ale
                   & ~(is_load & (state != S_DONE));

   assign mem_to_rf_bus = {rf_we_o, rf_waddr, rf_wdata};
   assign mem_to_wb_bus = {pc, rf_we_o, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table plus
// multi-cycle handshake, stall/bubble and reset sequences.
module tb_mem_stage_lsu;

   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   stall;
   logic [106:0] bus;
   logic         data_req, data_wr;
   logic [1:0]   data_size;
   logic [31:0]  data_addr, data_wdata, data_rdata;
   logic [3:0]   data_wstrb;
   logic         aok, dok;
   logic         stallreq_mem, excp_ale;
   logic [37:0]  rf_bus;
   logic [69:0]  wb_bus;

   logic         auto_st;
   logic [5:0]   man_st;

   int tests = 0;
   int fails = 0;

   logic         i_req, i_ale, i_wr;
   logic [1:0]   i_size;
   logic [3:0]   i_wstrb;
   logic [31:0]  i_wdata, i_addr;

   always #5 clk = ~clk;

   assign stall = auto_st ? (stallreq_mem ? 6'b011000 : 6'b0) : man_st;

   mem_stage_lsu dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .ex_to_mem_bus (bus),
      .data_req      (data_req),
      .data_wr       (data_wr),
      .data_size     (data_size),
      .data_addr     (data_addr),
      .data_wstrb    (data_wstrb),
      .data_wdata    (data_wdata),
      .data_addr_ok  (aok),
      .data_data_ok  (dok),
      .data_rdata    (data_rdata),
      .stallreq_mem  (stallreq_mem),
      .excp_ale      (excp_ale),
      .mem_to_rf_bus (rf_bus),
      .mem_to_wb_bus (wb_bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic        en, we;
      logic [2:0]  mt;
      logic        rfwe;
      logic [4:0]  wa;
      logic [31:0] res, sd, rdata;
      int          stalls;
      logic        req, wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        ale, chk, xrfwe;
      logic [31:0] xrfd;
   } vec_t;

   vec_t tv[11];

   function automatic logic [106:0] mk(
      input logic [31:0] pc, input logic en, input logic we,
      input logic [2:0] mt, input logic rfwe, input logic [4:0] wa,
      input logic [31:0] res, input logic [31:0] sd);
      return {pc, en, we, mt, rfwe, wa, res, sd};
   endfunction

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic nop();
      bus = '0;
      aok = 1'b0;
      dok = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // loads bus, drives addr_ok/data_ok on the given issue-relative
   // cycles, returns at the negedge of the first non-stalled cycle
   task automatic run_op(input int aok_at, input int dok_at,
                         output int stalls, output logic [7:0] hist);
      logic done;
      done   = 1'b0;
      stalls = 0;
      hist   = '0;
      @(posedge clk);
      for (int c = 0; c < 8; c++) begin
         #1;
         aok = (c == aok_at);
         dok = (c == dok_at);
         @(negedge clk);
         hist[c] = data_req;
         if (c == 0) begin
            i_req   = data_req;
            i_ale   = excp_ale;
            i_wr    = data_wr;
            i_size  = data_size;
            i_wstrb = data_wstrb;
            i_wdata = data_wdata;
            i_addr  = data_addr;
         end else if (data_req) begin
            check("req_stable",
                  {data_addr, data_wr, data_size, data_wstrb, data_wdata},
                  {i_addr, i_wr, i_size, i_wstrb, i_wdata});
         end
         if (!stallreq_mem) begin
            done = 1'b1;
            break;
         end
         stalls++;
         check("stale_fwd", {rf_bus[37], wb_bus[37]}, 2'b00);
         @(posedge clk);
      end
      check("op_timeout", done, 1'b1);
      aok = 1'b0;
      dok = 1'b0;
   endtask

   int          st;
   logic [7:0]  hist;

   initial begin
      tv[0]  = '{32'h100, 0, 0, 3'b000, 1, 5'd3, 32'h12345678, 0, 0,
                 0, 0, 0, 2'd0, 4'b0000, 32'h0, 0, 1, 1, 32'h12345678};
      tv[1]  = '{32'h104, 1, 0, 3'b011, 1, 5'd5, 32'h2, 0, 32'h80010000,
                 1, 1, 0, 2'd1, 4'b0000, 32'h0, 0, 1, 1, 32'h00008001};
      tv[2]  = '{32'h108, 1, 0, 3'b100, 1, 5'd6, 32'h1001, 0, 0,
                 0, 0, 0, 2'd0, 4'b0000, 32'h0, 1, 0, 0, 32'h0};
      tv[3]  = '{32'h10C, 1, 0, 3'b101, 1, 5'd7, 32'h1000, 0, 0,
                 0, 0, 0, 2'd0, 4'b0000, 32'h0, 1, 0, 0, 32'h0};
      tv[4]  = '{32'h110, 1, 1, 3'b000, 0, 5'd0, 32'h1001, 32'hA5, 0,
                 1, 1, 1, 2'd0, 4'b0010, 32'hA5A5A5A5, 0, 1, 0, 32'h1001};
      tv[5]  = '{32'h114, 1, 1, 3'b100, 0, 5'd0, 32'h2000, 32'hDEADBEEF,
                 0, 1, 1, 1, 2'd2, 4'b1111, 32'hDEADBEEF, 0, 1, 0,
                 32'h2000};
      tv[6]  = '{32'h118, 1, 0, 3'b010, 1, 5'd8, 32'h1002, 0, 32'h87650000,
                 1, 1, 0, 2'd1, 4'b0000, 32'h0, 0, 1, 1, 32'hFFFF8765};
      tv[7]  = '{32'h11C, 1, 0, 3'b001, 1, 5'd9, 32'h1001, 0, 32'h0000F000,
                 1, 1, 0, 2'd0, 4'b0000, 32'h0, 0, 1, 1, 32'h000000F0};
      tv[8]  = '{32'h120, 1, 0, 3'b000, 1, 5'd10, 32'h0, 0, 32'h7F,
                 1, 1, 0, 2'd0, 4'b0000, 32'h0, 0, 1, 1, 32'h7F};
      tv[9]  = '{32'h124, 1, 1, 3'b010, 0, 5'd0, 32'h3, 32'h1234, 0,
                 0, 0, 0, 2'd0, 4'b0000, 32'h0, 1, 0, 0, 32'h0};
      tv[10] = '{32'h128, 0, 0, 3'b000, 0, 5'd11, 32'hFFFFFFFF, 0, 0,
                 0, 0, 0, 2'd0, 4'b0000, 32'h0, 0, 1, 0, 32'hFFFFFFFF};

      rst = 1'b0;
      bus = '0;
      aok = 1'b0;
      dok = 1'b0;
      data_rdata = '0;
      auto_st = 1'b1;
      man_st = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_outs",
            {data_req, stallreq_mem, excp_ale, data_wstrb, data_wr},
            8'h0);
      check("rst_rf", rf_bus, 38'h0);
      check("rst_wb", wb_bus, 70'h0);
      rst = 1'b1;
      nop();

      for (int i = 0; i < 11; i++) begin
         bus = mk(tv[i].pc, tv[i].en, tv[i].we, tv[i].mt, tv[i].rfwe,
                  tv[i].wa, tv[i].res, tv[i].sd);
         data_rdata = tv[i].rdata;
         run_op(0, 0, st, hist);
         check($sformatf("v%0d_stalls", i), st, tv[i].stalls);
         check($sformatf("v%0d_req", i), i_req, tv[i].req);
         check($sformatf("v%0d_ale", i), i_ale, tv[i].ale);
         if (tv[i].chk) begin
            check($sformatf("v%0d_lanes", i),
                  {i_wr, i_size, i_wstrb, i_wdata},
                  {tv[i].wr, tv[i].size, tv[i].wstrb, tv[i].wdata});
            check($sformatf("v%0d_rf", i), rf_bus,
                  {tv[i].xrfwe, tv[i].wa, tv[i].xrfd});
            check($sformatf("v%0d_wb", i), wb_bus,
                  {tv[i].pc, tv[i].xrfwe, tv[i].wa, tv[i].xrfd});
         end else begin
            check($sformatf("v%0d_rfwe", i), {rf_bus[37], wb_bus[37]},
                  2'b00);
            check($sformatf("v%0d_pc", i), wb_bus[69:38], tv[i].pc);
         end
         nop();
      end

      // LB with addr_ok at issue and data_ok two cycles later
      bus = mk(32'h400, 1, 0, 3'b000, 1, 5'd12, 32'h00001003, 0);
      data_rdata = 32'h80FF1234;
      run_op(0, 2, st, hist);
      check("lb_stalls", st, 3);
      check("lb_size", i_size, 2'd0);
      check("lb_req_hist", hist, 8'b0000_0001);
      check("lb_rf", rf_bus, {1'b1, 5'd12, 32'hFFFFFF80});
      check("lb_wb", wb_bus, {32'h400, 1'b1, 5'd12, 32'hFFFFFF80});
      nop();

      // SH with addr_ok and data_ok each delayed one cycle
      bus = mk(32'h404, 1, 1, 3'b010, 0, 5'd0, 32'h00002002, 32'hABCD);
      run_op(1, 2, st, hist);
      check("sh_stalls", st, 3);
      check("sh_req_hist", hist, 8'b0000_0011);
      check("sh_lanes", {i_wr, i_size, i_wstrb, i_wdata},
            {1'b1, 2'd1, 4'b1100, 32'hABCDABCD});
      check("sh_wb", wb_bus, {32'h404, 1'b0, 5'd0, 32'h00002002});
      nop();

      // bubble and hold via the stall vector
      auto_st = 1'b0;
      man_st  = 6'b0;
      bus = mk(32'h200, 0, 0, 3'b000, 1, 5'd4, 32'h55, 0);
      @(posedge clk);
      @(negedge clk);
      check("st_load", wb_bus, {32'h200, 1'b1, 5'd4, 32'h55});
      man_st = 6'b011000;
      bus = mk(32'h300, 0, 0, 3'b000, 1, 5'd9, 32'h66, 0);
      @(posedge clk);
      @(negedge clk);
      check("st_hold_wb", wb_bus, {32'h200, 1'b1, 5'd4, 32'h55});
      check("st_hold_rf", rf_bus, {1'b1, 5'd4, 32'h55});
      man_st = 6'b001000;
      @(posedge clk);
      @(negedge clk);
      check("st_bubble_wb", wb_bus, 70'h0);
      check("st_bubble_rf", rf_bus, 38'h0);
      man_st = 6'b0;
      auto_st = 1'b1;
      nop();

      // reset asserted while waiting for data_ok
      bus = mk(32'h500, 1, 0, 3'b100, 1, 5'd13, 32'h1000, 0);
      @(posedge clk);
      #1 aok = 1'b1;
      @(negedge clk);
      check("rw_issue_req", data_req, 1'b1);
      @(posedge clk);
      #1 aok = 1'b0;
      @(negedge clk);
      check("rw_wait", {data_req, stallreq_mem}, 2'b01);
      #2 rst = 1'b0;
      #1;
      check("rw_rst_outs", {data_req, stallreq_mem}, 2'b00);
      check("rw_rst_rf", rf_bus, 38'h0);
      check("rw_rst_wb", wb_bus, 70'h0);
      @(negedge clk);
      rst = 1'b1;
      data_rdata = 32'hCAFEF00D;
      run_op(0, 0, st, hist);
      check("rw_re_stalls", st, 1);
      check("rw_re_req", hist, 8'b0000_0001);
      check("rw_re_rf", rf_bus, {1'b1, 5'd13, 32'hCAFEF00D});
      nop();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
